// File: rtl/reg_file_wb.sv
// reg_file_wb: 8-entry register file fed by the writeback-select mux.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   we           write enable for the writeback port
//   waddr/wdata  write address / write data (writeback mux output)
//   raddr_a/b    read port addresses
//   rdata_a/b    combinational read data with same-cycle write bypass
//   scan_freeze  1 = hold the debug scan position
//   scan_addr    register index currently shown on the debug scan port
//   scan_data    committed contents of register scan_addr (no bypass)
//   scan_tick    registered one-cycle pulse when scan_addr advances
//
// Register 0 is never written, so it stays at its reset value of zero.
module reg_file_wb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int SCAN_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              scan_freeze,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_tick
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [DATA_W-1:0] regs_q [NREG];

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic              scan_tick_q, scan_tick_d;

    // Register storage; address 0 is excluded from writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read ports: zero register first, then bypass of the write in flight.
    assign rdata_a = (raddr_a == '0)              ? '0    :
                     (we && (waddr == raddr_a))   ? wdata :
                                                    regs_q[raddr_a];

    assign rdata_b = (raddr_b == '0)              ? '0    :
                     (we && (waddr == raddr_b))   ? wdata :
                                                    regs_q[raddr_b];

    // Scan divider. While frozen everything holds and the tick is forced low;
    // with SCAN_DIV=1 CNT_LAST is 0, so every unfrozen cycle advances.
    always_comb begin
        cnt_d       = cnt_q;
        scan_addr_d = scan_addr_q;
        scan_tick_d = 1'b0;
        if (!scan_freeze) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                scan_addr_d = scan_addr_q + 1'b1;
                scan_tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            scan_addr_q <= '0;
            scan_tick_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            scan_addr_q <= scan_addr_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    assign scan_addr = scan_addr_q;
    assign scan_tick = scan_tick_q;
    assign scan_data = regs_q[scan_addr_q];

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: self-checking bench for reg_file_wb with SCAN_DIV=4.
// A behavioural model tracks register contents and the number of unfrozen
// clock edges since reset; scan position and tick are derived from that count.
module tb_reg_file_wb;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       scan_freeze;
    logic [2:0] scan_addr;
    logic [7:0] scan_data;
    logic       scan_tick;

    int checks = 0;
    int errors = 0;

    reg_file_wb #(
        .DATA_W  (8),
        .ADDR_W  (3),
        .SCAN_DIV(DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .scan_freeze(scan_freeze),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_regs [8] = '{default: 8'h00};
    int         m_runs = 0;     // unfrozen edges since reset
    bit         m_tick = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            m_runs = 0;
            m_tick = 1'b0;
        end else begin
            if (we && waddr != 3'd0) m_regs[waddr] = wdata;
            if (!scan_freeze) begin
                m_runs = m_runs + 1;
                m_tick = (m_runs % DIV) == 0;
            end else begin
                m_tick = 1'b0;
            end
        end
    end

    function automatic logic [7:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic [2:0] m_scan_addr();
        return 3'((m_runs / DIV) % 8);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_rdata_a", rdata_a, m_read(raddr_a));
        check("cyc_rdata_b", rdata_b, m_read(raddr_b));
        check("cyc_scan_addr", {5'd0, scan_addr}, {5'd0, m_scan_addr()});
        check("cyc_scan_data", scan_data, m_regs[m_scan_addr()]);
        check("cyc_scan_tick", {7'd0, scan_tick}, {7'd0, m_tick});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    // Wait (bounded) until the scan port shows address a, optionally on a fresh tick.
    task automatic wait_scan(input logic [2:0] a, input bit fresh);
        bit found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (scan_addr == a && (!fresh || scan_tick)) found = 1'b1;
            else step();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_scan: address %0d not reached (now %0d)", a, scan_addr);
        end
    endtask

    int         ticks;
    logic [2:0] a0;

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 8'h00;
        raddr_a = 3'd0; raddr_b = 3'd0; scan_freeze = 1'b0;
        step(); step();
        check("reset_scan_addr", {5'd0, scan_addr}, 8'h00);
        check("reset_scan_tick", {7'd0, scan_tick}, 8'h00);
        rst_n = 1'b1;

        // Write then read both ports.
        wr(3'd5, 8'h3C);
        raddr_a = 3'd5; raddr_b = 3'd5; #1;
        check("wr_rd_a", rdata_a, 8'h3C);
        check("wr_rd_b", rdata_b, 8'h3C);
        raddr_a = 3'd4; #1;
        check("unwritten_r4", rdata_a, 8'h00);

        // Bypass.
        wr(3'd2, 8'h11);
        raddr_a = 3'd2; raddr_b = 3'd2; #1;
        check("committed_r2", rdata_a, 8'h11);
        we = 1'b1; waddr = 3'd2; wdata = 8'h77; #1;
        check("bypass_a", rdata_a, 8'h77);
        check("bypass_b", rdata_b, 8'h77);
        step();
        we = 1'b0; #1;
        check("after_bypass", rdata_a, 8'h77);

        // Register 0 hardwired.
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr_a = 3'd0; #1;
        check("r0_during", rdata_a, 8'h00);
        step();
        we = 1'b0; #1;
        check("r0_after", rdata_a, 8'h00);

        // Scan contents and stepping.
        wr(3'd1, 8'h12);
        wr(3'd7, 8'h9E);
        wr(3'd6, 8'h21);
        wait_scan(3'd1, 1'b0);
        check("scan_r1", scan_data, 8'h12);
        wait_scan(3'd7, 1'b0);
        check("scan_r7", scan_data, 8'h9E);

        a0 = scan_addr;
        ticks = 0;
        for (int i = 0; i < 8 * DIV; i++) begin
            step();
            if (scan_tick) ticks++;
        end
        check("tick_count_32cyc", 8'(ticks), 8'd8);
        check("full_wrap_addr", {5'd0, scan_addr}, {5'd0, a0});

        // Freeze with a partially elapsed count.
        wait_scan(3'd3, 1'b1);
        step();
        a0 = scan_addr;
        scan_freeze = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (scan_tick) ticks++;
            check("frozen_addr", {5'd0, scan_addr}, {5'd0, a0});
        end
        check("frozen_ticks", 8'(ticks), 8'd0);
        scan_freeze = 1'b0;
        step(); step();
        check("resume_hold", {5'd0, scan_addr}, {5'd0, a0});
        step();
        check("resume_adv", {5'd0, scan_addr}, {5'd0, 3'(a0 + 3'd1)});
        check("resume_tick", {7'd0, scan_tick}, 8'h01);

        // Write to the register being scanned.
        wait_scan(3'd6, 1'b1);
        we = 1'b1; waddr = 3'd6; wdata = 8'h55; #1;
        check("scan_old_r6", scan_data, 8'h21);
        step();
        we = 1'b0; #1;
        check("scan_new_r6", scan_data, 8'h55);
        check("scan_still_6", {5'd0, scan_addr}, 8'h06);

        // Asynchronous reset mid-cycle, with a write attempted during reset.
        wr(3'd3, 8'hA5);
        raddr_a = 3'd3; #1;
        check("pre_reset_r3", rdata_a, 8'hA5);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_r3", rdata_a, 8'h00);
        check("async_rst_addr", {5'd0, scan_addr}, 8'h00);
        check("async_rst_data", scan_data, 8'h00);
        step();
        we = 1'b1; waddr = 3'd4; wdata = 8'hEE;
        step();
        we = 1'b0; rst_n = 1'b1; raddr_a = 3'd4; #1;
        check("rst_write_lost", rdata_a, 8'h00);
        step(); step(); step();
        check("post_rst_hold", {5'd0, scan_addr}, 8'h00);
        step();
        check("post_rst_adv", {5'd0, scan_addr}, 8'h01);
        check("post_rst_tick", {7'd0, scan_tick}, 8'h01);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 8-entry x 8-bit register file that sits directly downstream of the writeback-select 2:1 mux. It consumes the mux output as its write data.
- Provides two combinational read ports to the ALU/operand path, with same-cycle write-to-read bypass.
- Adds a free-running debug scan port. The scan port steps through all registers for the board LED/7-seg display.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 8, register and data width in bits.
- ADDR_W, 3, register address width; the file holds 2**ADDR_W entries.
- SCAN_DIV, 50000000, clock cycles each register is held on the debug scan port before advancing. Must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable for the writeback port.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data (output of the writeback-select mux).
- raddr_a  input  ADDR_W  read port A address.
- raddr_b  input  ADDR_W  read port B address.
- rdata_a  output  DATA_W  read port A data (combinational).
- rdata_b  output  DATA_W  read port B data (combinational).
- scan_freeze  input  1  1 = hold the current scan index.
- scan_addr  output  ADDR_W  index of the register currently shown on the scan port.
- scan_data  output  DATA_W  contents of register scan_addr.
- scan_tick  output  1  one-cycle pulse when scan_addr advances.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset (rst_n=0, asserted asynchronously, released synchronously to clk by the system):
  - All registers go to 0.
  - The scan divider counter goes to 0.
  - scan_addr goes to 0 and scan_tick goes to 0.
  - rdata_a, rdata_b and scan_data therefore read 0.
- Write:
  - On a rising clk edge with we=1 and waddr!=0, reg[waddr] <= wdata.
  - Writes to address 0 are ignored; reg[0] always reads 0.
  - we=0 leaves all registers unchanged.
- Read: rdata_x is combinational, with no added latency. Selection order:
  - raddr_x==0 -> 0.
  - else if we=1 and waddr==raddr_x -> wdata (bypass; the new value is visible in the same cycle as the write).
  - else reg[raddr_x].
- Both read ports may address the same register; each port applies the bypass rule independently.
- Scan port:
  - scan_data = reg[scan_addr], with no bypass; it reflects committed state only.
  - A divider counter cnt runs 0..SCAN_DIV-1 and increments every cycle while scan_freeze=0.
  - When cnt==SCAN_DIV-1 and scan_freeze=0:
    - cnt <= 0.
    - scan_addr <= scan_addr+1, wrapping 7->0.
    - scan_tick <= 1 for exactly one cycle (registered output).
  - scan_freeze=1: cnt, scan_addr and scan_tick=0 are all held. On release, counting resumes from the held cnt.
  - SCAN_DIV=1: scan_addr advances every cycle and scan_tick stays 1 continuously while unfrozen.
- Reset mid-operation: an in-flight write is discarded. The scan sequence restarts at address 0 with a full SCAN_DIV period.
- Widths: no arithmetic except the counters. cnt width is clog2(SCAN_DIV), with a minimum of 1. scan_addr wraps modulo 2**ADDR_W.

Test Plan:
- Reset: write 0xA5 to r3, assert rst_n=0 mid-cycle -> rdata_a with raddr_a=3 reads 0x00 immediately, without waiting for a clock edge; scan_addr=0.
- Write/read: we=1, waddr=5, wdata=0x3C for one edge, then raddr_a=5, raddr_b=5 -> both ports read 0x3C; raddr_a=4 -> 0x00.
- Bypass: r2=0x11 committed; in the same cycle drive we=1, waddr=2, wdata=0x77 with raddr_a=2 -> rdata_a=0x77 before the edge; after the edge with we=0, rdata_a is still 0x77.
- R0 hardwired: we=1, waddr=0, wdata=0xFF -> rdata_a with raddr_a=0 reads 0x00 during and after the write.
- Scan, SCAN_DIV=4, r1=0x12, r7=0x9E:
  - scan_addr steps 0,1,2,...,7,0 every 4 cycles.
  - scan_tick pulses once per step.
  - scan_data=0x12 while scan_addr=1 and 0x9E while scan_addr=7.
  - scan_freeze=1 for 10 cycles -> no change and no scan_tick; after release, advance occurs after the remaining count.
- Write during scan: scan_addr=6; write r6=0x55 -> scan_data shows the old value until the edge and 0x55 from the next cycle.
